// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO interconnect.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int MMIO_ERR_DATA = 0;

    // Index width that stays legal for a single-slave build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational priority address decoder: lowest matching slave index wins.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int                           NUM_SLAVES = 4,
    parameter int                           ADDR_W     = 32,
    parameter int                           IDX_W      = idx_w(NUM_SLAVES),
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scan from the top so the lowest matching index is the last writer.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_interconnect.sv
// Single-master MMIO interconnect with one outstanding access.
// Optional access timeout enabled by defining MMIO_TIMEOUT_EN.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int                           NUM_SLAVES  = 4,
    parameter int                           ADDR_W      = 32,
    parameter int                           DATA_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE    = {32'h4000_0000, 32'h3000_0000,
                                                           32'h2000_0000, 32'h1001_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK    = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                                           32'hF000_0000, 32'hFFFF_F800},
    parameter int                           TIMEOUT_CYC = 255
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ack
);

    localparam int IDX_W = idx_w(NUM_SLAVES);

    state_t           state;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_hit;
    logic             acked;
    logic             expired;

    mmio_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .addr (m_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign acked = s_ack[sel];

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    // WAIT is only entered from IDLE, so holding zero in IDLE clears it on entry.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)               cnt <= '0;
        else if (state == IDLE)   cnt <= '0;
        else if (state == WAIT)   cnt <= cnt + 1'b1;
    end

    assign expired = (state == WAIT) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sel     <= '0;
            s_req   <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_rdata <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req) begin
                        if (dec_hit) begin
                            state   <= WAIT;
                            sel     <= dec_idx;
                            s_req   <= NUM_SLAVES'(1) << dec_idx;
                            s_we    <= m_we;
                            s_addr  <= m_addr - SLV_BASE[dec_idx*ADDR_W +: ADDR_W];
                            s_wdata <= m_wdata;
                        end else begin
                            state   <= RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= DATA_W'(MMIO_ERR_DATA);
                        end
                    end
                end
                WAIT: begin
                    // A real ack beats a timeout landing in the same cycle.
                    if (acked) begin
                        state   <= RESP;
                        s_req   <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        m_rdata <= s_we ? '0 : s_rdata[sel*DATA_W +: DATA_W];
                    end else if (expired) begin
                        state   <= RESP;
                        s_req   <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= DATA_W'(MMIO_ERR_DATA);
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Table-driven scoreboard bench for mmio_interconnect; timeout vectors need MMIO_TIMEOUT_EN.
module tb_mmio_interconnect;

    logic         clk_in;
    logic         reset;
    logic         m_req;
    logic         m_we;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic         m_err;
    logic [3:0]   s_req;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   s_ack;

    mmio_interconnect #(.TIMEOUT_CYC(8)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          slv;
        int          delay;
        logic        stray;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_sreq;
        logic [31:0] exp_saddr;
        int          exp_lat;
        int          exp_hi;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int slv, input int delay, input logic stray,
                                input logic [31:0] rdata, input logic exp_err,
                                input logic [31:0] exp_rdata, input logic [3:0] exp_sreq,
                                input logic [31:0] exp_saddr, input int exp_lat, input int exp_hi);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.slv = slv; v.delay = delay;
        v.stray = stray; v.rdata = rdata; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        v.exp_sreq = exp_sreq; v.exp_saddr = exp_saddr; v.exp_lat = exp_lat; v.exp_hi = exp_hi;
        return v;
    endfunction

    // Drives one access, acting as the slave, and scores the response.
    task automatic run_vec(input vec_t v);
        resp_t e;
        resp_t g;
        int    cyc;
        int    hi;
        bit    got;
        bit    req_ok;
        @(negedge clk_in);
        for (int i = 0; i < 4; i++)
            s_rdata[i*32 +: 32] = (i == v.slv) ? v.rdata : (32'hDEAD_0000 | 32'(i));
        m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata;
        e.err = v.exp_err; e.rdata = v.exp_rdata;
        sb.push_back(e);
        cyc = 0; hi = 0; got = 1'b0; req_ok = 1'b1;
        while (!got && cyc < 40) begin
            @(negedge clk_in);
            cyc++;
            s_ack = '0;
            if (m_ready) begin
                got   = 1'b1;
                m_req = 1'b0;
                g = sb.pop_front();
                check("m_err", 32'(m_err), 32'(g.err));
                check("m_rdata", m_rdata, g.rdata);
            end else begin
                if (s_req != '0) hi++;
                if (s_req != v.exp_sreq) req_ok = 1'b0;
                if (cyc == 1 && v.exp_sreq != '0) begin
                    check("s_addr", s_addr, v.exp_saddr);
                    check("s_we", 32'(s_we), 32'(v.we));
                    check("s_wdata", s_wdata, v.wdata);
                end
                if (v.stray && cyc == 1) s_ack[1] = 1'b1;
                if (v.exp_sreq != '0 && cyc == v.delay + 1) s_ack[v.slv] = 1'b1;
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            m_req = 1'b0;
            sb.delete();
            $display("FAIL no_ready: addr 0x%08h got no m_ready in 40 cycles", v.addr);
        end
        check("latency", 32'(cyc), 32'(v.exp_lat));
        check("s_req_cycles", 32'(hi), 32'(v.exp_hi));
        check("s_req_pattern", 32'(req_ok), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_req"},   32'(s_req),   32'd0);
        check({tag, "_m_ready"}, 32'(m_ready), 32'd0);
        check({tag, "_m_err"},   32'(m_err),   32'd0);
        check({tag, "_m_rdata"}, m_rdata,      32'd0);
        check({tag, "_s_we"},    32'(s_we),    32'd0);
        check({tag, "_s_addr"},  s_addr,       32'd0);
        check({tag, "_s_wdata"}, s_wdata,      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ack = '0;

        //          we    addr          wdata         slv dly stray rdata         err  exp_rdata     sreq     saddr         lat hi
        vecs.push_back(mk(1'b0, 32'h1001_0010, 32'h0,        0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 4'b0001, 32'h0000_0010, 2, 1));
        vecs.push_back(mk(1'b1, 32'h3000_0004, 32'h55,       2, 5, 1'b0, 32'h1111_2222, 1'b0, 32'h0,         4'b0100, 32'h0000_0004, 7, 6));
        vecs.push_back(mk(1'b0, 32'h5000_0000, 32'h0,        0, 0, 1'b0, 32'h9999_9999, 1'b1, 32'h0,         4'b0000, 32'h0,         1, 0));
        vecs.push_back(mk(1'b0, 32'h4000_0008, 32'hABCD,     3, 3, 1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678, 4'b1000, 32'h0000_0008, 5, 4));
        vecs.push_back(mk(1'b0, 32'h2ABC_DEF0, 32'h0,        1, 1, 1'b0, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 4'b0010, 32'h0ABC_DEF0, 3, 2));
        vecs.push_back(mk(1'b0, 32'h1001_07FC, 32'h0,        0, 2, 1'b0, 32'h0BAD_BEEF, 1'b0, 32'h0BAD_BEEF, 4'b0001, 32'h0000_07FC, 4, 3));
        vecs.push_back(mk(1'b0, 32'h1001_0800, 32'h0,        0, 0, 1'b0, 32'h7777_7777, 1'b1, 32'h0,         4'b0000, 32'h0,         1, 0));
        vecs.push_back(mk(1'b1, 32'h3000_000F, 32'hFFFF_FFFF,2, 0, 1'b0, 32'h3333_3333, 1'b0, 32'h0,         4'b0100, 32'h0000_000F, 2, 1));
        vecs.push_back(mk(1'b0, 32'h4000_0010, 32'h0,        3, 0, 1'b0, 32'h4444_4444, 1'b1, 32'h0,         4'b0000, 32'h0,         1, 0));
`ifdef MMIO_TIMEOUT_EN
        vecs.push_back(mk(1'b0, 32'h4000_0004, 32'h0,        3, 99, 1'b0, 32'h0000_0077, 1'b1, 32'h0,         4'b1000, 32'h0000_0004, 9, 8));
        vecs.push_back(mk(1'b0, 32'h4000_0004, 32'h0,        3, 7,  1'b0, 32'h0000_0088, 1'b0, 32'h0000_0088, 4'b1000, 32'h0000_0004, 9, 8));
`endif

        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        @(negedge clk_in);
        reset = 1'b1;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Leave m_rdata non-zero, then pull reset in the middle of a WAIT.
        run_vec(mk(1'b0, 32'h2000_0100, 32'h0, 1, 0, 1'b0, 32'hFACE_0001, 1'b0, 32'hFACE_0001, 4'b0010, 32'h0000_0100, 2, 1));
        @(negedge clk_in);
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h3000_0008; m_wdata = 32'h0000_1234;
        @(negedge clk_in);
        check("midrst_pre_s_req", 32'(s_req), 32'h4);
        @(negedge clk_in);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        m_req = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        run_vec(mk(1'b0, 32'h1001_0020, 32'h0, 0, 1, 1'b0, 32'h600D_600D, 1'b0, 32'h600D_600D, 4'b0001, 32'h0000_0020, 3, 2));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_interconnect.md
MMIO_INTERCONNECT -- requirements
Module: mmio_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave channels (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter SLV_BASE, default {0x10010000, 0x20000000, 0x30000000, 0x40000000} packed, NUM_SLAVES*ADDR_W base addresses, slave 0 in low bits.
REQ-005 SHALL have parameter SLV_MASK, default {0xFFFFF800, 0xF0000000, 0xFFFFFFF0, 0xFFFFFFF0} packed, per-slave match masks.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255, maximum wait cycles per access.
REQ-007 clk_in  input  1  single clock; all logic on the rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 m_req  input  1  master access request, held until m_ready.
REQ-010 m_we  input  1  1 = write, 0 = read.
REQ-011 m_addr  input  ADDR_W  master byte address.
REQ-012 m_wdata  input  DATA_W  write data.
REQ-013 m_rdata  output  DATA_W  registered read data, valid while m_ready.
REQ-014 m_ready  output  1  one-cycle access-complete pulse.
REQ-015 m_err  output  1  qualifies m_ready: decode miss or timeout.
REQ-016 s_req  output  NUM_SLAVES  one-hot slave request.
REQ-017 s_we, s_addr (ADDR_W), s_wdata (DATA_W)  output  shared slave write-enable, offset address, write data.
REQ-018 s_rdata  input  NUM_SLAVES*DATA_W  packed slave read data.
REQ-019 s_ack  input  NUM_SLAVES  per-slave completion.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, RESP.
REQ-021 In IDLE with m_req=1, the block SHALL select the lowest index i where (m_addr & SLV_MASK[i]) == SLV_BASE[i].
REQ-022 On a hit, it SHALL latch m_we, m_wdata, index and s_addr = m_addr - SLV_BASE[i] (modulo 2^ADDR_W), then enter WAIT.
REQ-023 On a miss, it SHALL enter RESP with m_err=1 and m_rdata=0, and no s_req.
REQ-024 In WAIT, s_req[i] SHALL be 1, all other s_req bits SHALL be 0, and s_we/s_addr/s_wdata SHALL be held stable.
REQ-025 s_ack[i]=1 in WAIT SHALL capture s_rdata slice i into m_rdata on reads (0 on writes) and enter RESP with m_err=0.
REQ-026 s_ack bits of non-selected slaves, and any s_ack outside WAIT, SHALL be ignored.
REQ-027 RESP SHALL last one cycle with m_ready=1, then return to IDLE; m_req is not sampled in WAIT or RESP.
REQ-028 Zero-wait latency SHALL be fixed: m_req at cycle 0 gives s_req at cycle 1; s_ack at cycle 1 gives m_ready at cycle 2.
REQ-029 Back-to-back accesses SHALL be accepted: m_req high in the IDLE cycle after RESP starts a new access.

Reset
REQ-030 Assertion of reset (low) SHALL immediately force IDLE, s_req=0, m_ready=0, m_err=0, m_rdata=0, s_we=0, s_addr=0, s_wdata=0, and timeout counter=0, including mid-access.
REQ-031 After deassertion, the block SHALL accept a request on the first rising edge.

Configuration
REQ-032 With MMIO_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-033 If the counter reaches TIMEOUT_CYC without s_ack, the block SHALL deassert s_req and enter RESP with m_err=1 and m_rdata=0.
REQ-034 s_ack in the same cycle as the timeout SHALL win: normal response, m_err=0.
REQ-035 Without MMIO_TIMEOUT_EN, WAIT SHALL persist until s_ack and no counter logic SHALL exist.

Structure
REQ-036 Package mmio_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and constant MMIO_ERR_DATA = 0.
REQ-037 Sub-module mmio_addr_decode SHALL implement the combinational priority match (hit flag plus index).

Verification
REQ-038 Read 0x10010010, slave 0 acks in cycle 1 with 0xCAFEF00D -> s_addr=0x10, m_ready at cycle 2, m_rdata=0xCAFEF00D, m_err=0.
REQ-039 Write 0x30000004 data 0x55, slave 2 acks after 5 cycles -> s_req[2] high 6 cycles, s_wdata=0x55, s_we=1, m_ready with m_err=0.
REQ-040 Read 0x50000000 -> no s_req, m_ready at cycle 1 with m_err=1, m_rdata=0.
REQ-041 MMIO_TIMEOUT_EN, TIMEOUT_CYC=8, slave never acks -> s_req drops, m_err=1 after 8 WAIT cycles; ack exactly on cycle 8 -> m_err=0.
REQ-042 Reset asserted during WAIT -> all outputs 0 asynchronously; a later read completes normally.
REQ-043 Stray s_ack[1] during an access to slave 3 -> ignored; completion only on s_ack[3].
